cpu_run_ctrl: RTL

- Synthesizable run controller that sequences the CPU top's clock-domain control inputs (reset, enable, start), replacing the fixed delay-then-release stimulus in the CPU bench.
- Adds parametrised reset hold length, a cycle counter, an optional cycle budget with timeout, single-step mode, and halt/stop termination.
- Sits between the bench (or board buttons) and the CPU top, in the CPU's single clock domain.

---
 rtl/cpu_run_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// Run controller for the CPU top: holds the core in reset, releases it, then
// runs free or single-steps until halt, cycle budget exhaustion or stop.
module cpu_run_ctrl #(
    parameter int RESET_CYCLES = 4,
    parameter int CNT_W        = 32,
    parameter int MAX_CYCLES   = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go,
    input  logic             stop,
    input  logic             step_mode,
    input  logic             step,
    input  logic             halt_in,
    output logic             core_reset,
    output logic             core_enable,
    output logic             core_start,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam bit HAS_BUDGET = (MAX_CYCLES != 0);
    // Counter value at which the next enabled edge consumes the last budgeted cycle.
    localparam logic [CNT_W-1:0] BUDGET_LAST = CNT_W'((MAX_CYCLES == 0) ? 0 : MAX_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RST_HOLD,
        START,
        RUN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_q, timeout_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        timeout_d   = timeout_q;
        core_reset  = 1'b1;
        core_start  = 1'b0;
        core_enable = 1'b0;
        case (state_q)
            IDLE: begin
                if (go && !stop) begin
                    state_d   = RST_HOLD;
                    hold_d    = '0;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            RST_HOLD: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = START;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            START, RUN: begin
                core_reset  = 1'b0;
                core_start  = 1'b1;
                core_enable = ~step_mode | step;
                if (core_enable && (cnt_q != '1)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Halt outranks the budget so a coincident halt reports a clean finish.
                if (stop) begin
                    state_d = IDLE;
                end else if (halt_in) begin
                    state_d   = DONE;
                    timeout_d = 1'b0;
                end else if (HAS_BUDGET && core_enable && (cnt_q == BUDGET_LAST)) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                core_reset = 1'b0;
                if (stop) begin
                    state_d = IDLE;
                end else if (go) begin
                    state_d   = RST_HOLD;
                    hold_d    = '0;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign running     = (state_q == START) || (state_q == RUN);
    assign done        = (state_q == DONE);
    assign timeout     = timeout_q && (state_q == DONE);
    assign cycle_count = cnt_q;

endmodule
